// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the synchronous crossbar: FSM state encoding,
// selector width derivation and the identity-map reset value.
package crossbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } xbar_state_e;

  // Upper bound on NUM_CH*SEL_W for the identity-map helper.
  localparam int MAP_MAX_W = 1024;

  // Selector width for a given channel count; never below one bit.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Flattened map where output i selects input i; callers keep the low
  // num_ch*sel_w bits.
  function automatic logic [MAP_MAX_W-1:0] identity_map(input int num_ch, input int sel_w);
    logic [MAP_MAX_W-1:0] map;
    map = '0;
    for (int i = 0; i < num_ch; i++) begin
      for (int b = 0; b < sel_w; b++) begin
        if (i * sel_w + b < MAP_MAX_W) begin
          map[i * sel_w + b] = i[b];
        end
      end
    end
    return map;
  endfunction

endpackage

// File: rtl/crossbar_out_mux.sv
// One crossbar output: selects an input channel and registers it, driving
// zero when disabled or when the selector points past the last channel.
module crossbar_out_mux
  import crossbar_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IO_WIDTH = 1,
  parameter int SEL_W    = sel_width(NUM_CH)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [SEL_W-1:0]           sel_in,
  input  logic                       en_in,
  input  logic [NUM_CH*IO_WIDTH-1:0] inputs_in,
  output logic [IO_WIDTH-1:0]        data_out
);

  logic [IO_WIDTH-1:0] pick_d;
  logic [IO_WIDTH-1:0] data_q;

  // Input select; an out-of-range selector matches nothing and yields zero.
  always_comb begin
    pick_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_in == SEL_W'(k)) begin
        pick_d = inputs_in[k*IO_WIDTH +: IO_WIDTH];
      end
    end
  end

  // Output register with enable gating.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q <= '0;
    end else begin
      data_q <= en_in ? pick_d : '0;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/crossbar_switch_sync.sv
// NxN crossbar with registered outputs. Routing is written into a shadow map
// over a valid/ready port and copied to the active map at the first frame
// boundary after a commit, so remaps never land mid-frame.
// Optional: define CROSSBAR_CONFLICT_CHECK_EN to add the conflict_out port.
module crossbar_switch_sync
  import crossbar_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IO_WIDTH = 1,
  parameter int SEL_W    = sel_width(NUM_CH)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       cfg_valid_in,
  output logic                       cfg_ready_out,
  input  logic [SEL_W-1:0]           cfg_out_idx_in,
  input  logic [SEL_W-1:0]           cfg_sel_in,
  input  logic                       cfg_en_in,
  output logic                       cfg_err_out,
  input  logic                       commit_in,
  input  logic                       frame_start_in,
  output logic                       commit_pending_out,
  input  logic [NUM_CH*IO_WIDTH-1:0] inputs_in,
  output logic [NUM_CH*IO_WIDTH-1:0] outputs_out,
  output logic [NUM_CH*SEL_W-1:0]    active_sel_out
`ifdef CROSSBAR_CONFLICT_CHECK_EN
  ,
  output logic                       conflict_out
`endif
);

  localparam logic [MAP_MAX_W-1:0]    ID_MAP_FULL = identity_map(NUM_CH, SEL_W);
  localparam logic [NUM_CH*SEL_W-1:0] ID_MAP      = ID_MAP_FULL[NUM_CH*SEL_W-1:0];
  localparam logic [SEL_W:0]          NUM_CH_EXT  = (SEL_W+1)'(NUM_CH);

  xbar_state_e state_q, state_d;
  logic        cfg_accept;
  logic        cfg_idx_bad;
  logic        apply;
  logic        cfg_err_q;

  logic [NUM_CH*SEL_W-1:0] active_sel_flat;
  logic [NUM_CH*SEL_W-1:0] eff_sel_flat;
  logic [NUM_CH-1:0]       eff_en;

  assign cfg_accept  = cfg_valid_in & cfg_ready_out;
  assign cfg_idx_bad = ({1'b0, cfg_out_idx_in} >= NUM_CH_EXT);
  assign apply       = (state_q == ST_APPLY);

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs; shadow is writable only in IDLE.
  always_comb begin
    state_d            = state_q;
    cfg_ready_out      = 1'b0;
    commit_pending_out = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_out      = 1'b1;
        commit_pending_out = 1'b0;
        if (commit_in) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_start_in) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Error pulse for an accepted write to a nonexistent output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_accept & cfg_idx_bad;
    end
  end

  assign cfg_err_out = cfg_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SEL_W-1:0] shadow_sel_q, active_sel_q;
    logic             shadow_en_q, active_en_q;
    logic             wr_hit;

    assign wr_hit = cfg_accept && !cfg_idx_bad && (cfg_out_idx_in == SEL_W'(gi));

    // Shadow entry for this output, written through the config port.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        shadow_sel_q <= ID_MAP[gi*SEL_W +: SEL_W];
        shadow_en_q  <= 1'b0;
      end else if (wr_hit) begin
        shadow_sel_q <= cfg_sel_in;
        shadow_en_q  <= cfg_en_in;
      end
    end

    // Active entry, loaded from shadow during the single APPLY cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        active_sel_q <= ID_MAP[gi*SEL_W +: SEL_W];
        active_en_q  <= 1'b0;
      end else if (apply) begin
        active_sel_q <= shadow_sel_q;
        active_en_q  <= shadow_en_q;
      end
    end

    // During APPLY the mux already uses the incoming map so the outputs
    // show the new routing on the very next cycle.
    assign eff_sel_flat[gi*SEL_W +: SEL_W]    = apply ? shadow_sel_q : active_sel_q;
    assign eff_en[gi]                         = apply ? shadow_en_q : active_en_q;
    assign active_sel_flat[gi*SEL_W +: SEL_W] = active_sel_q;

    crossbar_out_mux #(
      .NUM_CH  (NUM_CH),
      .IO_WIDTH(IO_WIDTH),
      .SEL_W   (SEL_W)
    ) u_out_mux (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .sel_in   (eff_sel_flat[gi*SEL_W +: SEL_W]),
      .en_in    (eff_en[gi]),
      .inputs_in(inputs_in),
      .data_out (outputs_out[gi*IO_WIDTH +: IO_WIDTH])
    );
  end

  assign active_sel_out = active_sel_flat;

`ifdef CROSSBAR_CONFLICT_CHECK_EN
  logic conflict_d, conflict_q;

  // Flag shared inputs among enabled outputs and enabled out-of-range selectors.
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eff_en[i] && ({1'b0, eff_sel_flat[i*SEL_W +: SEL_W]} >= NUM_CH_EXT)) begin
        conflict_d = 1'b1;
      end
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (eff_en[i] && eff_en[j] &&
            (eff_sel_flat[i*SEL_W +: SEL_W] == eff_sel_flat[j*SEL_W +: SEL_W])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Conflict flag register; tracks the map the outputs are using.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_out = conflict_q;
`endif

endmodule
